video_fb: RTL and testbench

- Double-buffered 1-bpp framebuffer with CPU word-write port, frame-aligned buffer swap, hardware back-buffer clear and continuous pixel scan-out.
- Parametrised in columns, rows and bus width.
- Sits between the CPU store path and the display/VRAM serialiser.
- The CPU only ever writes the back buffer; the front buffer is scanned out.

---
 rtl/video_fb.sv | 156 +++++++++++++++
 tb/tb_video_fb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fb.sv
// video_fb: double-buffered 1-bpp framebuffer with CPU word writes, frame-aligned swap,
// hardware back-buffer clear and continuous scan-out. Optional swap-done irq: VIDEO_FB_SWAP_IRQ_EN.
module video_fb #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 30,
  parameter int PIX_AW = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  data_in,
  input  logic              pix_en,
  output logic              pix_valid,
  output logic              pix_out,
  output logic [PIX_AW-1:0] pix_addr,
  output logic              frame_start,
  output logic              swap_pending,
  output logic              clear_busy,
  output logic              front_sel,
  output logic              irq
);

  localparam int NPIX     = COLS * ROWS;
  localparam int FB_WORDS = NPIX / BUS_W;
  localparam int WORD_AW  = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam int BIT_AW   = (BUS_W > 1) ? $clog2(BUS_W) : 1;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  clr_state_t         state_q, state_d;
  logic [WORD_AW-1:0] clr_idx_q, clr_idx_d;
  logic               clr_we;

  logic [BUS_W-1:0]   mem [2][FB_WORDS];

  logic [PIX_AW-1:0]  pos_q;
  logic               pending_d;
  logic               data_hit, ctrl_hit, swap_req, pos_last, swap_go;

  logic [31:0]        pos_i;
  logic [WORD_AW-1:0] pos_word;
  logic [BIT_AW-1:0]  pos_bit;
  logic [BUS_W-1:0]   front_word;

  assign data_hit = we && (addr < ADDR_W'(FB_WORDS));
  assign ctrl_hit = we && (addr == ADDR_W'(FB_WORDS));
  assign swap_req = ctrl_hit && data_in[0];
  assign pos_last = (pos_q == PIX_AW'(NPIX - 1));

  // The swap only lands on the last pixel of a frame so a frame never mixes buffers.
  assign swap_go   = pix_en && pos_last && swap_pending && !clear_busy;
  assign pending_d = swap_go ? swap_req : (swap_pending | swap_req);

  // Clear FSM: one back-buffer word per cycle.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clear_busy = 1'b0;
    clr_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_hit && data_in[1]) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        clr_we     = 1'b1;
        if (clr_idx_q == WORD_AW'(FB_WORDS - 1)) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Buffer RAM: a single write port shared by the clear engine and the CPU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[~front_sel][clr_idx_q] <= '0;
      end else if (data_hit) begin
        mem[~front_sel][addr[WORD_AW-1:0]] <= data_in;
      end
    end
  end

  // Pixel n sits in word n/BUS_W, MSB-first.
  assign pos_i      = 32'(pos_q);
  assign pos_word   = WORD_AW'(pos_i / 32'(BUS_W));
  assign pos_bit    = BIT_AW'(32'(BUS_W - 1) - (pos_i % 32'(BUS_W)));
  assign front_word = mem[front_sel][pos_word];

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q        <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      pix_valid    <= 1'b0;
      pix_out      <= 1'b0;
      pix_addr     <= '0;
      frame_start  <= 1'b0;
    end else begin
      swap_pending <= pending_d;
      if (swap_go) begin
        front_sel <= ~front_sel;
      end
      if (pix_en) begin
        pix_valid   <= 1'b1;
        pix_addr    <= pos_q;
        pix_out     <= front_word[pos_bit];
        frame_start <= (pos_q == '0);
        pos_q       <= pos_last ? '0 : pos_q + 1'b1;
      end else begin
        pix_valid <= 1'b0;
      end
    end
  end

`ifdef VIDEO_FB_SWAP_IRQ_EN
  logic front_prev;

  // Pulse one cycle after front_sel changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_prev <= 1'b0;
      irq        <= 1'b0;
    end else begin
      front_prev <= front_sel;
      irq        <= front_sel ^ front_prev;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_video_fb.sv
// Self-checking bench for video_fb: pixel-level reference model, randomized stimulus.
module tb_video_fb;

  localparam int COLS     = 16;
  localparam int ROWS     = 16;
  localparam int BUS_W    = 32;
  localparam int ADDR_W   = 30;
  localparam int NPIX     = COLS * ROWS;
  localparam int FB_WORDS = NPIX / BUS_W;
  localparam int PIX_AW   = 8;

  logic              clk = 1'b0;
  logic              rst, we, pix_en;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  data_in;
  logic              pix_valid, pix_out, frame_start, swap_pending, clear_busy, front_sel, irq;
  logic [PIX_AW-1:0] pix_addr;

  video_fb #(.COLS(COLS), .ROWS(ROWS), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in), .pix_en(pix_en),
    .pix_valid(pix_valid), .pix_out(pix_out), .pix_addr(pix_addr), .frame_start(frame_start),
    .swap_pending(swap_pending), .clear_busy(clear_busy), .front_sel(front_sel), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [13:0] dut_vec;
  assign dut_vec = {pix_valid, pix_addr, frame_start, swap_pending, clear_busy, front_sel, irq};

  // Reference model: buffers as pixel arrays, with a per-pixel "known" flag for unwritten RAM.
  bit m_px [2][NPIX];
  bit m_kn [2][NPIX];
  int m_pos, m_pa, m_clr_left;
  bit m_front, m_pending, m_pv, m_po, m_kpo, m_fs, m_irq, m_last_apply;

  function automatic logic [13:0] model_vec();
    return {m_pv, 8'(m_pa), m_fs, m_pending, (m_clr_left > 0), m_front, m_irq};
  endfunction

  task automatic model_step();
    bit busy, apply, ctrl, sreq, back;
    int a, w;
    if (rst) begin
      m_pos = 0; m_pa = 0; m_clr_left = 0; m_front = 0; m_pending = 0;
      m_pv = 0; m_po = 0; m_kpo = 1; m_fs = 0; m_irq = 0; m_last_apply = 0;
      return;
    end
    busy  = (m_clr_left > 0);
    apply = pix_en && (m_pos == NPIX - 1) && m_pending && !busy;
    ctrl  = we && (addr == ADDR_W'(FB_WORDS));
    sreq  = ctrl && data_in[0];
    back  = !m_front;
`ifdef VIDEO_FB_SWAP_IRQ_EN
    m_irq = m_last_apply;
`else
    m_irq = 0;
`endif
    m_last_apply = apply;
    if (pix_en) begin
      m_pa  = m_pos;
      m_po  = m_px[m_front][m_pos];
      m_kpo = m_kn[m_front][m_pos];
      m_pv  = 1;
      m_fs  = (m_pos == 0);
      m_pos = (m_pos + 1) % NPIX;
    end else begin
      m_pv = 0;
    end
    if (busy) begin
      w = FB_WORDS - m_clr_left;
      for (int b = 0; b < BUS_W; b++) begin
        m_px[back][w * BUS_W + b] = 0;
        m_kn[back][w * BUS_W + b] = 1;
      end
      m_clr_left--;
    end else if (we && addr < ADDR_W'(FB_WORDS)) begin
      a = int'(addr);
      for (int b = 0; b < BUS_W; b++) begin
        m_px[back][a * BUS_W + b] = data_in[BUS_W - 1 - b];
        m_kn[back][a * BUS_W + b] = 1;
      end
    end
    if (ctrl && data_in[1] && !busy) m_clr_left = FB_WORDS;
    m_pending = apply ? sreq : (m_pending | sreq);
    if (apply) m_front = !m_front;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit r, input bit w, input int a, input logic [BUS_W-1:0] d, input bit pe);
    rst = r; we = w; addr = ADDR_W'(a); data_in = d; pix_en = pe;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, '0, 1);
    tick(); tick();
    tests++;
    if (dut_vec !== 14'h0 || pix_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got %h/%b want 0000/0", dut_vec, pix_out);
    end
    drive(0, 0, 0, '0, 0);
  endtask

  // Zero both buffers: clear back, swap, clear the other, then reset.
  task automatic test_clear_fill();
    int busy_cnt;
    bit done;
    for (int pass = 0; pass < 2; pass++) begin
      drive(0, 1, FB_WORDS, 32'h2, 0);
      tick();
      drive(0, 0, 0, '0, 0);
      busy_cnt = 0;
      for (int i = 0; i < 20 && clear_busy === 1'b1; i++) begin
        busy_cnt++;
        tick();
      end
      tests++;
      if (busy_cnt != FB_WORDS) begin
        fails++;
        $display("FAIL clear_len got %0d want %0d", busy_cnt, FB_WORDS);
      end
      if (pass == 0) begin
        drive(0, 1, FB_WORDS, 32'h1, 1);
        tick();
        drive(0, 0, 0, '0, 1);
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
          tick();
          tests++;
          if (dut_vec !== model_vec()) begin
            fails++;
            $display("FAIL fill_scan got %h want %h", dut_vec, model_vec());
          end
          if (front_sel === 1'b1) done = 1;
        end
        tests++;
        if (!done) begin
          fails++;
          $display("FAIL fill_swap_timeout got front_sel=%b want 1", front_sel);
        end
        drive(0, 0, 0, '0, 0);
      end
    end
    drive(1, 0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0);
  endtask

  task automatic test_scan();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < NPIX + 1; i++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec() || pix_out !== 1'b0 || pix_addr !== 8'(i % NPIX)) begin
        fails++;
        $display("FAIL scan_zero i=%0d got %h/%b want %h/0", i, dut_vec, pix_out, model_vec());
      end
    end
  endtask

  task automatic test_swap();
    bit done = 0;
    drive(0, 1, 0, 32'h8000_0001, 1);
    tick();
    drive(0, 1, FB_WORDS, 32'h1, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec() || (front_sel === 1'b0 && swap_pending !== 1'b1)) begin
        fails++;
        $display("FAIL swap_wait got %h want %h", dut_vec, model_vec());
      end
      if (front_sel === 1'b1) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL swap_timeout got front_sel=%b want 1", front_sel);
    end
    for (int i = 0; i < NPIX; i++) begin
      tick();
      tests++;
      if (pix_out !== (pix_addr == 8'd0 || pix_addr == 8'd31) || front_sel !== 1'b1 ||
          dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL swap_frame addr=%0d got %b/%h want %b/%h", pix_addr, pix_out, dut_vec,
                 (pix_addr == 8'd0 || pix_addr == 8'd31), model_vec());
      end
    end
  endtask

  task automatic test_double_swap();
    bit f0;
    int toggles = 0;
    bit prev;
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 600 && m_pos != 10; i++) tick();
    f0 = front_sel;
    prev = front_sel;
    drive(0, 1, FB_WORDS, 32'h1, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 40; i++) tick();
    drive(0, 1, FB_WORDS, 32'h1, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 2 * NPIX; i++) begin
      tick();
      if (front_sel !== prev) toggles++;
      prev = front_sel;
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL dbl_swap_scan got %h want %h", dut_vec, model_vec());
      end
    end
    tests++;
    if (toggles != 1 || swap_pending !== 1'b0 || front_sel !== !f0) begin
      fails++;
      $display("FAIL dbl_swap got toggles=%0d pending=%b want toggles=1 pending=0", toggles, swap_pending);
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    bit done = 0;
    drive(0, 1, FB_WORDS, 32'h2, $urandom_range(0, 1));
    tick();
    for (int i = 0; i < 12; i++) begin
      if (i == 3) drive(0, 1, 3, $urandom | 32'h1, $urandom_range(0, 1));
      else drive(0, 0, 0, '0, $urandom_range(0, 1));
      if (clear_busy === 1'b1) busy_cnt++;
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL clear_run got %h want %h", dut_vec, model_vec());
      end
    end
    tests++;
    if (busy_cnt != FB_WORDS) begin
      fails++;
      $display("FAIL clear_busy_len got %0d want %0d", busy_cnt, FB_WORDS);
    end
    drive(0, 1, 5, $urandom, 1);
    tick();
    drive(0, 1, FB_WORDS, 32'h1, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (m_pa == NPIX - 1 && m_pv) done = 1;
    end
    tests++;
    if (!done || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL clear_swap_timeout got pending=%b want 0", swap_pending);
    end
    for (int i = 0; i < NPIX; i++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec() || (m_kpo && pix_out !== m_po) ||
          (pix_addr >= 8'd96 && pix_addr < 8'd128 && pix_out !== 1'b0)) begin
        fails++;
        $display("FAIL clear_frame addr=%0d got %b/%h want %b/%h", pix_addr, pix_out, dut_vec, m_po, model_vec());
      end
    end
  endtask

  task automatic test_deferred();
    bit f0;
    int ends = 0;
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 600 && m_pos != NPIX - 5; i++) tick();
    f0 = front_sel;
    drive(0, 1, FB_WORDS, 32'h3, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 3 * NPIX && ends < 2; i++) begin
      tick();
      tests++;
      if (dut_vec !== model_vec()) begin
        fails++;
        $display("FAIL defer_scan got %h want %h", dut_vec, model_vec());
      end
      if (pix_addr == 8'(NPIX - 1)) begin
        ends++;
        tests++;
        if (ends == 1 && (front_sel !== f0 || swap_pending !== 1'b1)) begin
          fails++;
          $display("FAIL defer_first got front=%b pending=%b want front=%b pending=1", front_sel, swap_pending, f0);
        end else if (ends == 2 && (front_sel !== !f0 || swap_pending !== 1'b0)) begin
          fails++;
          $display("FAIL defer_second got front=%b pending=%b want front=%b pending=0", front_sel, swap_pending, !f0);
        end
      end
    end
    tests++;
    if (ends != 2) begin
      fails++;
      $display("FAIL defer_timeout got ends=%0d want 2", ends);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, FB_WORDS, 32'h3, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    tick(); tick();
    drive(1, 0, 0, '0, 1);
    tick();
    tests++;
    if (dut_vec !== 14'h0 || pix_out !== 1'b0 || dut_vec !== model_vec()) begin
      fails++;
      $display("FAIL reset_mid got %h/%b want 0000/0", dut_vec, pix_out);
    end
    drive(0, 0, 0, '0, 0);
  endtask

  task automatic test_random();
    int a;
    logic [BUS_W-1:0] d;
    for (int i = 0; i < 3000; i++) begin
      a = $urandom_range(0, FB_WORDS + 2);
      d = $urandom;
      if (a == FB_WORDS) d = BUS_W'($urandom_range(0, 7) == 0 ? 2 : 0) | BUS_W'($urandom_range(0, 1));
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3, a, d, $urandom_range(0, 3) != 0);
      tick();
      tests++;
      if (dut_vec !== model_vec() || (m_kpo && pix_out !== m_po)) begin
        fails++;
        $display("FAIL random i=%0d got %h/%b want %h/%b", i, dut_vec, pix_out, model_vec(), m_po);
      end
    end
    drive(0, 0, 0, '0, 0);
  endtask

  initial begin
    drive(1, 0, 0, '0, 0);
    test_reset();
    test_clear_fill();
    test_scan();
    test_swap();
    test_double_swap();
    test_clear();
    test_deferred();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
